symbol_aligner: RTL and testbench
=================================

SYMBOL_ALIGNER -- requirements
Module: symbol_aligner

Interface
REQ-001 SHALL have parameter LOCK_COMMAS, default 2: boundary-aligned commas, including the first one found, needed to reach lock.
REQ-002 SHALL have parameter ERR_LIMIT, default 4: accumulated decode errors that force a return to HUNT.
REQ-003 SHALL have parameter GOOD_RUN, default 16: consecutive clean symbols that remove one accumulated error.
REQ-004 INTERCLK  in  1  single clock; one serial line bit per cycle.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 iBit  in  1  serial line bit; the first bit received of each symbol is code bit a.
REQ-007 iDecErr  in  1  decode/disparity error pulse from the downstream 8b/10b decoder; each asserted cycle counts as one error.
REQ-008 oData  out  10  aligned symbol, ordered {a,b,c,d,e,i,f,g,h,j} (oData[9]=a), for direct connection to the decoder iData.
REQ-009 oValid  out  1  one-cycle strobe marking oData as a new symbol.
REQ-010 COMMA  out  1  qualifies oValid: the symbol is a comma.
REQ-011 LOCKED  out  1  high while the state is LOCK.
REQ-012 ALIGN_ERR  out  1  one-cycle pulse on loss of lock or realignment while locked.

Function
REQ-013 Window W SHALL be {sr[8:0], iBit}, where sr is a 9-bit shift register updated every cycle as sr <= W[8:0].
REQ-014 W SHALL be a comma when W[9:3] equals 0011111 or 1100000.
REQ-015 Phase counter bit_cnt (0..9) SHALL increment every cycle and wrap from 9 to 0; a boundary is a cycle with bit_cnt==9.
REQ-016 The state machine SHALL have three states: HUNT, ACQ and LOCK.
REQ-017 HUNT: on a comma at any offset, SHALL set bit_cnt<=0, set comma_cnt<=1 and go to ACQ; otherwise SHALL remain in HUNT.
REQ-018 ACQ, comma on a boundary: SHALL increment comma_cnt; when it reaches LOCK_COMMAS, SHALL go to LOCK and emit that comma.
REQ-019 ACQ, comma off a boundary: SHALL realign (bit_cnt<=0, comma_cnt<=1) and remain in ACQ.
REQ-020 ACQ, non-comma boundary: SHALL have no effect.
REQ-021 LOCK: at every boundary, SHALL register oData<=W and oValid<=1, with COMMA<=1 if W is a comma; latency is 1 cycle after the 10th bit is present on iBit.
REQ-022 LOCK: a comma off a boundary SHALL pulse ALIGN_ERR, realign as in REQ-019, go to ACQ and emit nothing that cycle.
REQ-023 LOCK: each iDecErr cycle SHALL increment err_cnt (saturating) and clear good_cnt.
REQ-024 LOCK: when err_cnt reaches ERR_LIMIT, SHALL go to HUNT and pulse ALIGN_ERR.
REQ-025 LOCK: each emitted symbol with no iDecErr in its 10-cycle span SHALL increment good_cnt; at GOOD_RUN, SHALL decrement err_cnt (floor 0) and clear good_cnt.
REQ-026 If iDecErr and a boundary coincide, the error SHALL be counted and that symbol SHALL NOT count as good.
REQ-027 err_cnt and good_cnt SHALL clear on every entry to HUNT or ACQ.
REQ-028 oValid, COMMA and ALIGN_ERR SHALL be low in every cycle not specified above.
REQ-029 oData SHALL hold its last value between strobes.
REQ-030 iDecErr SHALL be ignored outside LOCK.

Reset
REQ-031 While Reset=1, the state SHALL be HUNT and sr, bit_cnt, comma_cnt, err_cnt, good_cnt, oData, oValid, COMMA, LOCKED and ALIGN_ERR SHALL all be 0.
REQ-032 Reset asserted mid-symbol or mid-lock SHALL take effect immediately with no output strobe.
REQ-033 After reset release, the block SHALL start in HUNT with the first clock edge.

Structure
REQ-034 A shared package SHALL hold the state enum, the two 7-bit comma patterns and the counter widths.
REQ-035 The comma check SHALL be a combinational sub-module, comma_detect (10-bit in, 1-bit out), reusable by the decoder side.
REQ-036 The remaining logic (FSM, counters, output registers) SHALL be in symbol_aligner; RTL size 150-300 lines.

Verification
REQ-037 Stream K28.5- (0011111010) then K28.5+ (1100000101), then repeating D21.5 (1010101010), with 3 junk bits first -> LOCKED rises after the second comma, oData=1100000101 with COMMA=1, then oData=1010101010 every 10 cycles.
REQ-038 Only D21.5 forever -> no comma at any offset, state stays HUNT, oValid never asserts.
REQ-039 Locked, then insert 4 extra bits and a K28.5 -> ALIGN_ERR pulse, LOCKED low, relock on the next aligned comma at the new phase.
REQ-040 Locked, drive 4 iDecErr pulses within 10 symbols -> LOCKED falls on the 4th, ALIGN_ERR pulse; with 3 pulses followed by 16 clean symbols, err_cnt returns to 2 and lock holds.
REQ-041 Reset asserted at bit 5 of a locked symbol -> all outputs 0 the same cycle; after release, LOCK requires two fresh commas.
REQ-042 iDecErr on the same cycle as a boundary -> err_cnt increments and good_cnt stays 0.

Source files
------------

// File: rtl/symbol_aligner_pkg.sv
// Shared types and constants for the 10-bit serial symbol aligner.
// Holds the FSM state encoding, the comma patterns and the counter widths.
package symbol_aligner_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam int SYM_W     = 10;
    localparam int BIT_CNT_W = 4;
    localparam int CNT_W     = 8;

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = 4'd9;
    localparam logic [BIT_CNT_W-1:0] BIT_ZERO = 4'd0;
    localparam logic [BIT_CNT_W-1:0] BIT_ONE  = 4'd1;

    localparam logic [CNT_W-1:0] CNT_ZERO = 8'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 8'd1;
    localparam logic [CNT_W-1:0] CNT_MAX  = 8'd255;

    // Seven leading bits a..f,i of a K28.x comma, both disparities.
    localparam logic [6:0] COMMA_NEG = 7'b0011111;
    localparam logic [6:0] COMMA_POS = 7'b1100000;

    localparam logic [SYM_W-1:0] COMMA_MASK = 10'b11_1111_1000;

    // True when the leading seven bits of a symbol-wide window form a comma.
    function automatic logic comma_match(input logic [SYM_W-1:0] sym);
        logic [SYM_W-1:0] masked;
        masked = sym & COMMA_MASK;
        return (masked == {COMMA_NEG, 3'b000}) || (masked == {COMMA_POS, 3'b000});
    endfunction

endpackage

// File: rtl/symbol_aligner_comma_detect.sv
// Combinational comma detector over a 10-bit window; also usable on the
// decoder side to flag comma symbols.
module comma_detect
    import symbol_aligner_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output logic             comma
);

    assign comma = comma_match(sym);

endmodule

// File: rtl/symbol_aligner.sv
// Serial-to-symbol aligner: hunts for commas, acquires symbol phase, and
// emits aligned 10-bit symbols while tracking decoder error density.
module symbol_aligner
    import symbol_aligner_pkg::*;
#(
    parameter int LOCK_COMMAS = 2,
    parameter int ERR_LIMIT   = 4,
    parameter int GOOD_RUN    = 16
)(
    input  logic             INTERCLK,
    input  logic             Reset,
    input  logic             iBit,
    input  logic             iDecErr,
    output logic [SYM_W-1:0] oData,
    output logic             oValid,
    output logic             COMMA,
    output logic             LOCKED,
    output logic             ALIGN_ERR
);

    localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_COMMAS);
    localparam logic [CNT_W-1:0] ERR_TGT  = CNT_W'(ERR_LIMIT);
    localparam logic [CNT_W-1:0] GOOD_TGT = CNT_W'(GOOD_RUN);

    state_t                 state_r, state_s;
    logic [8:0]             sr_r;
    logic [BIT_CNT_W-1:0]   bit_cnt_r, bit_cnt_s;
    logic [CNT_W-1:0]       comma_cnt_r, comma_cnt_s;
    logic [CNT_W-1:0]       err_cnt_r, err_cnt_s;
    logic [CNT_W-1:0]       good_cnt_r, good_cnt_s;
    logic [CNT_W-1:0]       err_inc_s;
    logic                   sym_err_r, sym_err_s;
    logic [SYM_W-1:0]       window_s;
    logic                   comma_s;
    logic                   boundary_s;
    logic                   emit_s;
    logic                   align_err_s;

    assign window_s   = {sr_r, iBit};
    assign boundary_s = (bit_cnt_r == BIT_LAST);
    assign err_inc_s  = (iDecErr && (err_cnt_r != CNT_MAX)) ? (err_cnt_r + CNT_ONE) : err_cnt_r;

    comma_detect u_comma_detect (
        .sym   (window_s),
        .comma (comma_s)
    );

    // Next-state, phase, counter and strobe decisions.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = boundary_s ? BIT_ZERO : (bit_cnt_r + BIT_ONE);
        comma_cnt_s = comma_cnt_r;
        err_cnt_s   = err_cnt_r;
        good_cnt_s  = good_cnt_r;
        sym_err_s   = sym_err_r;
        emit_s      = 1'b0;
        align_err_s = 1'b0;

        case (state_r)
            ST_HUNT: begin
                sym_err_s = 1'b0;
                if (comma_s) begin
                    state_s     = ST_ACQ;
                    bit_cnt_s   = BIT_ZERO;
                    comma_cnt_s = CNT_ONE;
                    err_cnt_s   = CNT_ZERO;
                    good_cnt_s  = CNT_ZERO;
                end else begin
                    state_s = ST_HUNT;
                end
            end

            ST_ACQ: begin
                sym_err_s = 1'b0;
                if (comma_s && boundary_s) begin
                    comma_cnt_s = comma_cnt_r + CNT_ONE;
                    if (comma_cnt_s >= LOCK_TGT) begin
                        state_s    = ST_LOCK;
                        emit_s     = 1'b1;
                        err_cnt_s  = CNT_ZERO;
                        good_cnt_s = CNT_ZERO;
                    end else begin
                        state_s = ST_ACQ;
                    end
                end else if (comma_s) begin
                    bit_cnt_s   = BIT_ZERO;
                    comma_cnt_s = CNT_ONE;
                end else begin
                    state_s = ST_ACQ;
                end
            end

            ST_LOCK: begin
                // Error-limit loss of lock wins over a simultaneous realignment.
                if (iDecErr && (err_inc_s >= ERR_TGT)) begin
                    state_s     = ST_HUNT;
                    align_err_s = 1'b1;
                    comma_cnt_s = CNT_ZERO;
                    err_cnt_s   = CNT_ZERO;
                    good_cnt_s  = CNT_ZERO;
                    sym_err_s   = 1'b0;
                end else if (comma_s && !boundary_s) begin
                    state_s     = ST_ACQ;
                    align_err_s = 1'b1;
                    bit_cnt_s   = BIT_ZERO;
                    comma_cnt_s = CNT_ONE;
                    err_cnt_s   = CNT_ZERO;
                    good_cnt_s  = CNT_ZERO;
                    sym_err_s   = 1'b0;
                end else begin
                    err_cnt_s = err_inc_s;
                    if (iDecErr) begin
                        good_cnt_s = CNT_ZERO;
                    end else begin
                        good_cnt_s = good_cnt_r;
                    end
                    if (boundary_s) begin
                        emit_s    = 1'b1;
                        sym_err_s = 1'b0;
                        // A symbol is clean only if no error touched any of its ten bits.
                        if (!iDecErr && !sym_err_r) begin
                            if ((good_cnt_r + CNT_ONE) >= GOOD_TGT) begin
                                good_cnt_s = CNT_ZERO;
                                err_cnt_s  = (err_cnt_r != CNT_ZERO) ? (err_cnt_r - CNT_ONE) : CNT_ZERO;
                            end else begin
                                good_cnt_s = good_cnt_r + CNT_ONE;
                            end
                        end else begin
                            good_cnt_s = CNT_ZERO;
                        end
                    end else begin
                        sym_err_s = sym_err_r | iDecErr;
                    end
                end
            end

            default: begin
                state_s     = ST_HUNT;
                bit_cnt_s   = BIT_ZERO;
                comma_cnt_s = CNT_ZERO;
                err_cnt_s   = CNT_ZERO;
                good_cnt_s  = CNT_ZERO;
                sym_err_s   = 1'b0;
            end
        endcase
    end

    // State, shift register and counter registers.
    always_ff @(posedge INTERCLK or posedge Reset) begin
        if (Reset) begin
            state_r     <= ST_HUNT;
            sr_r        <= 9'd0;
            bit_cnt_r   <= BIT_ZERO;
            comma_cnt_r <= CNT_ZERO;
            err_cnt_r   <= CNT_ZERO;
            good_cnt_r  <= CNT_ZERO;
            sym_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            sr_r        <= window_s[8:0];
            bit_cnt_r   <= bit_cnt_s;
            comma_cnt_r <= comma_cnt_s;
            err_cnt_r   <= err_cnt_s;
            good_cnt_r  <= good_cnt_s;
            sym_err_r   <= sym_err_s;
        end
    end

    // Registered outputs; oData holds between strobes.
    always_ff @(posedge INTERCLK or posedge Reset) begin
        if (Reset) begin
            oData     <= 10'd0;
            oValid    <= 1'b0;
            COMMA     <= 1'b0;
            LOCKED    <= 1'b0;
            ALIGN_ERR <= 1'b0;
        end else begin
            oValid    <= emit_s;
            COMMA     <= emit_s & comma_s;
            LOCKED    <= (state_s == ST_LOCK);
            ALIGN_ERR <= align_err_s;
            if (emit_s) begin
                oData <= window_s;
            end else begin
                oData <= oData;
            end
        end
    end

endmodule

// File: tb/tb_symbol_aligner.sv
// Self-checking bench for symbol_aligner: directed scenarios plus random
// streams, checked each cycle against a behavioural model of the aligner.
module tb_symbol_aligner;

    localparam int LOCK_COMMAS = 2;
    localparam int ERR_LIMIT   = 4;
    localparam int GOOD_RUN    = 16;

    localparam logic [9:0] K_NEG = 10'b0011111010;
    localparam logic [9:0] K_POS = 10'b1100000101;
    localparam logic [9:0] D215  = 10'b1010101010;

    logic       INTERCLK = 1'b0;
    logic       Reset    = 1'b1;
    logic       iBit     = 1'b0;
    logic       iDecErr  = 1'b0;
    logic [9:0] oData;
    logic       oValid, COMMA, LOCKED, ALIGN_ERR;

    int checks = 0;
    int errors = 0;

    symbol_aligner #(.LOCK_COMMAS(LOCK_COMMAS), .ERR_LIMIT(ERR_LIMIT), .GOOD_RUN(GOOD_RUN)) dut (
        .INTERCLK  (INTERCLK),
        .Reset     (Reset),
        .iBit      (iBit),
        .iDecErr   (iDecErr),
        .oData     (oData),
        .oValid    (oValid),
        .COMMA     (COMMA),
        .LOCKED    (LOCKED),
        .ALIGN_ERR (ALIGN_ERR)
    );

    always #5 INTERCLK = ~INTERCLK;

    // Model: mode 0=hunting, 1=acquiring, 2=locked; m_next is the absolute
    // cycle of the next symbol boundary.
    int         m_mode, m_commas, m_errs, m_good, m_cyc, m_next;
    logic       m_span_err;
    logic [9:0] m_hist;
    logic [9:0] m_data;
    logic       m_valid, m_cm, m_ae;

    int          diff_cnt = 0;
    int          n_valid  = 0;
    int          n_ae     = 0;
    logic [13:0] last_act, last_exp;

    task automatic model_reset();
        m_mode = 0; m_commas = 0; m_errs = 0; m_good = 0;
        m_cyc = 0; m_next = 9; m_span_err = 1'b0; m_hist = 10'd0;
        m_data = 10'd0; m_valid = 1'b0; m_cm = 1'b0; m_ae = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic e);
        logic cm, bnd;
        m_hist = {m_hist[8:0], b};
        cm  = (m_hist[9:3] == 7'b0011111) || (m_hist[9:3] == 7'b1100000);
        bnd = (m_cyc == m_next);
        if (bnd) m_next = m_cyc + 10;
        m_valid = 1'b0; m_cm = 1'b0; m_ae = 1'b0;
        if (m_mode == 0) begin
            if (cm) begin m_mode = 1; m_commas = 1; m_next = m_cyc + 10; m_errs = 0; m_good = 0; end
        end else if (m_mode == 1) begin
            if (cm && bnd) begin
                m_commas++;
                if (m_commas >= LOCK_COMMAS) begin
                    m_mode = 2; m_data = m_hist; m_valid = 1'b1; m_cm = 1'b1;
                    m_errs = 0; m_good = 0; m_span_err = 1'b0;
                end
            end else if (cm) begin
                m_commas = 1; m_next = m_cyc + 10;
            end
        end else begin
            if (e && (m_errs + 1 >= ERR_LIMIT)) begin
                m_mode = 0; m_ae = 1'b1; m_errs = 0; m_good = 0; m_span_err = 1'b0;
            end else if (cm && !bnd) begin
                m_mode = 1; m_ae = 1'b1; m_commas = 1; m_next = m_cyc + 10;
                m_errs = 0; m_good = 0; m_span_err = 1'b0;
            end else begin
                if (e) begin m_errs++; m_good = 0; end
                if (bnd) begin
                    m_data = m_hist; m_valid = 1'b1; m_cm = cm;
                    if (!e && !m_span_err) begin
                        m_good++;
                        if (m_good == GOOD_RUN) begin
                            m_good = 0;
                            if (m_errs > 0) m_errs--;
                        end
                    end
                    m_span_err = 1'b0;
                end else if (e) begin
                    m_span_err = 1'b1;
                end
            end
        end
        m_cyc++;
    endtask

    // One line bit: drive on the falling edge, advance the model on the
    // rising edge, then sample the DUT just after it.
    task automatic tick(input logic b, input logic e);
        @(negedge INTERCLK);
        iBit = b; iDecErr = e;
        @(posedge INTERCLK);
        model_step(b, e);
        #1;
        if ({oData, oValid, COMMA, LOCKED, ALIGN_ERR} !== {m_data, m_valid, m_cm, (m_mode == 2), m_ae}) begin
            diff_cnt++;
            last_act = {oData, oValid, COMMA, LOCKED, ALIGN_ERR};
            last_exp = {m_data, m_valid, m_cm, (m_mode == 2), m_ae};
        end
        if (oValid === 1'b1) n_valid++;
        if (ALIGN_ERR === 1'b1) n_ae++;
    endtask

    task automatic send_sym(input logic [9:0] sym, input logic [9:0] em);
        for (int i = 9; i >= 0; i--) tick(sym[i], em[i]);
    endtask

    task automatic do_reset();
        @(negedge INTERCLK);
        Reset = 1'b1; iBit = 1'b0; iDecErr = 1'b0;
        @(negedge INTERCLK);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic lock_up();
        logic [2:0] junk;
        junk = 3'($urandom);
        for (int i = 2; i >= 0; i--) tick(junk[i], 1'b0);
        send_sym(K_NEG, 10'd0);
        send_sym(K_POS, 10'd0);
    endtask

    function automatic logic [9:0] off_bnd_err();
        logic [9:0] one;
        one = 10'd1;
        return one << $urandom_range(9, 1);
    endfunction

    task automatic test_reset();
        @(negedge INTERCLK);
        Reset = 1'b1;
        #2;
        checks++;
        if ({oData, oValid, COMMA, LOCKED, ALIGN_ERR} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", {oData, oValid, COMMA, LOCKED, ALIGN_ERR}, 14'd0);
        end
        do_reset();
    endtask

    task automatic test_basic_lock();
        int d0, v0;
        do_reset();
        d0 = diff_cnt; v0 = n_valid;
        lock_up();
        checks++;
        if (LOCKED !== 1'b1 || oValid !== 1'b1 || COMMA !== 1'b1 || oData !== K_POS) begin
            errors++;
            $display("FAIL basic_lock_strobe: got L%b V%b C%b data %b expected L1 V1 C1 data %b", LOCKED, oValid, COMMA, oData, K_POS);
        end
        for (int s = 0; s < 6; s++) send_sym(D215, 10'd0);
        checks++;
        if (n_valid - v0 !== 7 || oData !== D215 || COMMA !== 1'b0) begin
            errors++;
            $display("FAIL basic_data_strobes: got %0d strobes data %b expected 7 strobes data %b", n_valid - v0, oData, D215);
        end
        checks++;
        if (diff_cnt !== d0) begin
            errors++;
            $display("FAIL basic_trace: got %0d cycle diffs (last %b vs %b) expected 0", diff_cnt - d0, last_act, last_exp);
        end
    endtask

    task automatic test_no_comma();
        int d0, v0;
        do_reset();
        d0 = diff_cnt; v0 = n_valid;
        for (int i = 0; i < $urandom_range(9, 0); i++) tick(1'b0, 1'b0);
        for (int s = 0; s < 20; s++) send_sym(D215, 10'd0);
        checks++;
        if (n_valid !== v0 || LOCKED !== 1'b0) begin
            errors++;
            $display("FAIL no_comma: got %0d strobes locked %b expected 0 strobes locked 0", n_valid - v0, LOCKED);
        end
        checks++;
        if (diff_cnt !== d0) begin
            errors++;
            $display("FAIL no_comma_trace: got %0d cycle diffs expected 0", diff_cnt - d0);
        end
    endtask

    task automatic test_realign();
        int d0, a0;
        logic [3:0] slip;
        do_reset();
        lock_up();
        for (int s = 0; s < 3; s++) send_sym(D215, 10'd0);
        d0 = diff_cnt; a0 = n_ae;
        slip = 4'b0110;
        for (int i = 3; i >= 0; i--) tick(slip[i], 1'b0);
        send_sym(K_NEG, 10'd0);
        checks++;
        if (ALIGN_ERR !== 1'b1 || LOCKED !== 1'b0 || oValid !== 1'b0 || n_ae - a0 !== 1) begin
            errors++;
            $display("FAIL realign_pulse: got AE%b L%b V%b pulses %0d expected AE1 L0 V0 pulses 1", ALIGN_ERR, LOCKED, oValid, n_ae - a0);
        end
        send_sym(K_POS, 10'd0);
        checks++;
        if (LOCKED !== 1'b1 || oData !== K_POS || COMMA !== 1'b1) begin
            errors++;
            $display("FAIL realign_relock: got L%b data %b C%b expected L1 data %b C1", LOCKED, oData, COMMA, K_POS);
        end
        for (int s = 0; s < 3; s++) send_sym(D215, 10'd0);
        checks++;
        if (diff_cnt !== d0) begin
            errors++;
            $display("FAIL realign_trace: got %0d cycle diffs expected 0", diff_cnt - d0);
        end
    endtask

    task automatic test_dec_err();
        int d0, a0;
        do_reset();
        lock_up();
        send_sym(D215, 10'd0);
        d0 = diff_cnt; a0 = n_ae;
        for (int s = 0; s < 3; s++) send_sym(D215, off_bnd_err());
        checks++;
        if (LOCKED !== 1'b1) begin
            errors++;
            $display("FAIL err_three_hold: got locked %b expected 1", LOCKED);
        end
        send_sym(D215, off_bnd_err());
        checks++;
        if (LOCKED !== 1'b0 || n_ae - a0 !== 1) begin
            errors++;
            $display("FAIL err_fourth_unlock: got locked %b pulses %0d expected locked 0 pulses 1", LOCKED, n_ae - a0);
        end
        send_sym(K_NEG, 10'd0);
        send_sym(K_POS, 10'd0);
        for (int s = 0; s < 3; s++) send_sym(D215, off_bnd_err());
        for (int s = 0; s < GOOD_RUN; s++) send_sym(D215, 10'd0);
        send_sym(D215, off_bnd_err());
        checks++;
        if (LOCKED !== 1'b1) begin
            errors++;
            $display("FAIL err_decay_hold: got locked %b expected 1", LOCKED);
        end
        send_sym(D215, off_bnd_err());
        checks++;
        if (LOCKED !== 1'b0) begin
            errors++;
            $display("FAIL err_decay_unlock: got locked %b expected 0", LOCKED);
        end
        checks++;
        if (diff_cnt !== d0) begin
            errors++;
            $display("FAIL err_trace: got %0d cycle diffs (last %b vs %b) expected 0", diff_cnt - d0, last_act, last_exp);
        end
    endtask

    task automatic test_err_on_boundary();
        int d0;
        do_reset();
        lock_up();
        send_sym(D215, 10'd0);
        d0 = diff_cnt;
        send_sym(D215, 10'd1);
        for (int s = 0; s < GOOD_RUN - 1; s++) send_sym(D215, 10'd0);
        for (int s = 0; s < 2; s++) send_sym(D215, off_bnd_err());
        checks++;
        if (LOCKED !== 1'b1) begin
            errors++;
            $display("FAIL bnd_err_hold: got locked %b expected 1", LOCKED);
        end
        send_sym(D215, off_bnd_err());
        checks++;
        if (LOCKED !== 1'b0) begin
            errors++;
            $display("FAIL bnd_err_counted: got locked %b expected 0", LOCKED);
        end
        checks++;
        if (diff_cnt !== d0) begin
            errors++;
            $display("FAIL bnd_err_trace: got %0d cycle diffs expected 0", diff_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_lock();
        int d0;
        do_reset();
        lock_up();
        for (int s = 0; s < 2; s++) send_sym(D215, 10'd0);
        for (int i = 9; i >= 5; i--) tick(D215[i], 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({oData, oValid, COMMA, LOCKED, ALIGN_ERR} !== 14'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b expected %b", {oData, oValid, COMMA, LOCKED, ALIGN_ERR}, 14'd0);
        end
        @(negedge INTERCLK);
        Reset = 1'b0;
        model_reset();
        d0 = diff_cnt;
        send_sym(K_NEG, 10'd0);
        send_sym(D215, 10'd0);
        send_sym(D215, 10'd0);
        checks++;
        if (LOCKED !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_one_comma: got locked %b expected 0", LOCKED);
        end
        send_sym(K_POS, 10'd0);
        checks++;
        if (LOCKED !== 1'b1 || oData !== K_POS) begin
            errors++;
            $display("FAIL mid_reset_relock: got locked %b data %b expected locked 1 data %b", LOCKED, oData, K_POS);
        end
        checks++;
        if (diff_cnt !== d0) begin
            errors++;
            $display("FAIL mid_reset_trace: got %0d cycle diffs expected 0", diff_cnt - d0);
        end
    endtask

    task automatic test_random();
        int d0, r;
        logic [9:0] sym, em, one;
        do_reset();
        d0 = diff_cnt;
        lock_up();
        one = 10'd1;
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(9, 0);
            em = ($urandom_range(7, 0) == 0) ? (one << $urandom_range(9, 0)) : 10'd0;
            if (r <= 1)      sym = K_NEG;
            else if (r == 2) sym = K_POS;
            else if (r <= 6) sym = D215;
            else             sym = 10'($urandom);
            if (r == 9) begin
                for (int i = 0; i < $urandom_range(9, 1); i++) tick(1'($urandom), 1'b0);
            end
            send_sym(sym, em);
        end
        checks++;
        if (diff_cnt !== d0) begin
            errors++;
            $display("FAIL random_trace: got %0d cycle diffs (last %b vs %b) expected 0", diff_cnt - d0, last_act, last_exp);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_lock();
        test_no_comma();
        test_realign();
        test_dec_err();
        test_err_on_boundary();
        test_reset_mid_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
